// File: rtl/config_pkg.sv
// config_pkg -- shared configuration for the row-reduction datapath.
//   reduce_op_t          : reduction selector (SUM, MAX)
//   reduce_state_t       : FSM state encoding of rowwise_reduce
//   D, fixed_point_t     : row length and element format (signed Q8.8)
//   vector_t             : one row of D elements, element 0 in the low bits
//   acc_t                : widened signed accumulator (no overflow over D adds)
//   fixed_point_saturate : clamp an accumulator value into fixed_point_t
package config_pkg;

  typedef enum logic [0:0] {
    SUM = 1'b0,
    MAX = 1'b1
  } reduce_op_t;

  typedef enum logic [1:0] {
    WAITING_FOR_IN  = 2'd0,
    WORKING         = 2'd1,
    WAITING_FOR_OUT = 2'd2
  } reduce_state_t;

  localparam int unsigned D        = 4;
  localparam int unsigned FP_WIDTH = 16;
  localparam int unsigned FP_FRAC  = 8;
  localparam int unsigned IDX_W    = $clog2(D);
  localparam int unsigned ACC_W    = FP_WIDTH + IDX_W;

  typedef logic signed [FP_WIDTH-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0]       vector_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam fixed_point_t FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam fixed_point_t FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

  // Clamp a widened signed value into the fixed_point_t range.
  function automatic fixed_point_t fixed_point_saturate(input acc_t v);
    fixed_point_t r;
    if (v > acc_t'(FP_MAX)) begin
      r = FP_MAX;
    end else if (v < acc_t'(FP_MIN)) begin
      r = FP_MIN;
    end else begin
      r = v[FP_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rowwise_reduce.sv
// rowwise_reduce -- reduces one row of D fixed-point elements to a single value,
// one element per cycle.
//   operation   : SUM (saturated sum) or MAX (maximum plus its lowest index)
//   clk_i/rst_i : clock, asynchronous active-high reset
//   a_i         : row to reduce, captured on the input handshake
//   in_valid_i / in_ready_o   : input handshake
//   result_o / index_o        : reduction result (index_o is 0 for SUM)
//   out_valid_o / out_ready_i : output handshake
// Latency is D edges from accept to out_valid_o; one row per D+2 cycles.
module rowwise_reduce
  import config_pkg::*;
#(
  parameter reduce_op_t operation = SUM
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  vector_t          a_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output fixed_point_t     result_o,
  output logic [IDX_W-1:0] index_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  reduce_state_t    state_q,  state_d;
  vector_t          row_q,    row_d;
  logic [IDX_W-1:0] cnt_q,    cnt_d;
  acc_t             acc_q,    acc_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  fixed_point_t     result_q, result_d;
  logic [IDX_W-1:0] index_q,  index_d;

  fixed_point_t     elem_s;
  acc_t             acc_step_s;
  logic [IDX_W-1:0] idx_step_s;

  // Handshakes come straight from the registered state.
  assign in_ready_o  = (state_q == WAITING_FOR_IN);
  assign out_valid_o = (state_q == WAITING_FOR_OUT);
  assign result_o    = result_q;
  assign index_o     = index_q;

  // Next-state and datapath: combine row[cnt] into the accumulator each WORKING cycle.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    result_d   = result_q;
    index_d    = index_q;

    elem_s     = row_q[cnt_q];
    acc_step_s = acc_q;
    idx_step_s = idx_q;
    if (operation == SUM) begin
      acc_step_s = acc_q + acc_t'(elem_s);
    end else if (acc_t'(elem_s) > acc_q) begin
      // Strictly greater only, so ties keep the earlier (lower) index.
      acc_step_s = acc_t'(elem_s);
      idx_step_s = cnt_q;
    end else begin
      acc_step_s = acc_q;
      idx_step_s = idx_q;
    end

    case (state_q)
      WAITING_FOR_IN: begin
        if (in_valid_i) begin
          row_d   = a_i;
          cnt_d   = '0;
          acc_d   = (operation == SUM) ? '0 : acc_t'(FP_MIN);
          idx_d   = '0;
          state_d = WORKING;
        end else begin
          state_d = WAITING_FOR_IN;
        end
      end
      WORKING: begin
        acc_d = acc_step_s;
        idx_d = idx_step_s;
        if (cnt_q == IDX_W'(D - 1)) begin
          cnt_d    = '0;
          result_d = (operation == SUM) ? fixed_point_saturate(acc_step_s)
                                        : acc_step_s[FP_WIDTH-1:0];
          index_d  = (operation == SUM) ? '0 : idx_step_s;
          state_d  = WAITING_FOR_OUT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = WORKING;
        end
      end
      WAITING_FOR_OUT: begin
        if (out_ready_i) begin
          state_d = WAITING_FOR_IN;
        end else begin
          state_d = WAITING_FOR_OUT;
        end
      end
      default: begin
        state_d = WAITING_FOR_IN;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= WAITING_FOR_IN;
      row_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      index_q  <= index_d;
    end
  end

endmodule

// File: tb/tb_rowwise_reduce.sv
// tb_rowwise_reduce -- drives a SUM and a MAX instance of rowwise_reduce with
// identical stimulus and compares against a plain-arithmetic reference model.
module tb_rowwise_reduce;
  import config_pkg::*;

  localparam int FP_HI = (1 <<< (FP_WIDTH - 1)) - 1;
  localparam int FP_LO = -(1 <<< (FP_WIDTH - 1));
  localparam int ONE   = 1 <<< FP_FRAC;

  logic             clk_i = 1'b0;
  logic             rst_i;
  vector_t          a_i;
  logic             in_valid_i;
  logic             out_ready_i;

  logic             s_in_ready, s_out_valid, m_in_ready, m_out_valid;
  fixed_point_t     s_result, m_result;
  logic [IDX_W-1:0] s_index, m_index;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  rowwise_reduce #(.operation(SUM)) u_sum (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .in_valid_i(in_valid_i),
    .in_ready_o(s_in_ready), .result_o(s_result), .index_o(s_index),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready_i)
  );

  rowwise_reduce #(.operation(MAX)) u_max (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .in_valid_i(in_valid_i),
    .in_ready_o(m_in_ready), .result_o(m_result), .index_o(m_index),
    .out_valid_o(m_out_valid), .out_ready_i(out_ready_i)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: plain integer sum of the row, clamped to the element range.
  function automatic int ref_sum(input vector_t r);
    int s;
    fixed_point_t e;
    s = 0;
    for (int i = 0; i < D; i++) begin
      e = r[i];
      s += int'(e);
    end
    if (s > FP_HI) s = FP_HI;
    if (s < FP_LO) s = FP_LO;
    return s;
  endfunction

  // Reference: first position holding the largest element.
  function automatic int ref_max_idx(input vector_t r);
    int best, bi;
    fixed_point_t e;
    e = r[0];
    best = int'(e);
    bi = 0;
    for (int i = 1; i < D; i++) begin
      e = r[i];
      if (int'(e) > best) begin
        best = int'(e);
        bi = i;
      end
    end
    return bi;
  endfunction

  function automatic int ref_max_val(input vector_t r);
    fixed_point_t e;
    e = r[ref_max_idx(r)];
    return int'(e);
  endfunction

  function automatic vector_t rand_row();
    vector_t r;
    for (int i = 0; i < D; i++) begin
      if ($urandom_range(0, 2) == 0)
        r[i] = fixed_point_t'($urandom_range(0, 3) * ONE);
      else
        r[i] = fixed_point_t'($urandom);
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag, input vector_t r);
    check_eq({tag, "_sum"},     int'(s_result), ref_sum(r));
    check_eq({tag, "_sum_idx"}, int'(s_index),  0);
    check_eq({tag, "_max"},     int'(m_result), ref_max_val(r));
    check_eq({tag, "_max_idx"}, int'(m_index),  ref_max_idx(r));
  endtask

  // One row through both instances; output is held back for 'hold' cycles.
  task automatic run_row(input string tag, input vector_t r, input int hold);
    int n;
    int lat;
    a_i = r;
    in_valid_i = 1'b1;
    out_ready_i = 1'b0;
    n = 0;
    while (!(s_in_ready && m_in_ready) && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_in_ready"}, int'(s_in_ready && m_in_ready), 1);
    step();
    in_valid_i = 1'b0;
    a_i = rand_row();
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, D);
    check_eq({tag, "_max_valid"}, int'(m_out_valid), 1);
    check_outputs(tag, r);
    for (int h = 0; h < hold; h++) begin
      in_valid_i = 1'b1;
      a_i = rand_row();
      step();
      check_eq({tag, "_hold_valid"}, int'(s_out_valid && m_out_valid), 1);
      check_eq({tag, "_hold_in_ready"}, int'(s_in_ready || m_in_ready), 0);
      check_outputs({tag, "_hold"}, r);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check_eq({tag, "_release_in_ready"}, int'(s_in_ready && m_in_ready), 1);
    check_eq({tag, "_release_valid"}, int'(s_out_valid || m_out_valid), 0);
    check_outputs({tag, "_kept"}, r);
  endtask

  initial begin
    vector_t r;
    vector_t rows [4];
    vector_t exp_q [$];
    vector_t e;
    int got, last_out, k, nvalid;
    logic acc;

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    a_i = '0;
    step();
    step();
    rst_i = 1'b0;
    check_eq("reset_in_ready", int'(s_in_ready && m_in_ready), 1);
    check_eq("reset_out_valid", int'(s_out_valid || m_out_valid), 0);
    check_eq("reset_sum_result", int'(s_result), 0);
    check_eq("reset_max_result", int'(m_result), 0);
    check_eq("reset_max_index", int'(m_index), 0);

    // Mixed-sign row: 1.0 + 2.0 - 0.5 + 0.25 = 2.75
    r[0] = fixed_point_t'(ONE);
    r[1] = fixed_point_t'(2 * ONE);
    r[2] = fixed_point_t'(-ONE / 2);
    r[3] = fixed_point_t'(ONE / 4);
    run_row("mixed", r, 0);
    check_eq("mixed_sum_2p75", int'(s_result), 11 * ONE / 4);

    // Tie on the maximum keeps the lowest index; output back-pressured 10 cycles.
    r[0] = fixed_point_t'(-3 * ONE);
    r[1] = fixed_point_t'(5 * ONE);
    r[2] = fixed_point_t'(5 * ONE);
    r[3] = fixed_point_t'(ONE);
    run_row("tie", r, 10);
    check_eq("tie_max_5", int'(m_result), 5 * ONE);
    check_eq("tie_idx_1", int'(m_index), 1);

    for (int i = 0; i < D; i++) r[i] = fixed_point_t'(FP_HI);
    run_row("sat_hi", r, 0);
    check_eq("sat_hi_sum", int'(s_result), FP_HI);
    for (int i = 0; i < D; i++) r[i] = fixed_point_t'(FP_LO);
    run_row("sat_lo", r, 0);
    check_eq("sat_lo_sum", int'(s_result), FP_LO);

    for (int t = 0; t < 12; t++) begin
      run_row("rand", rand_row(), int'($urandom_range(0, 3)));
    end

    // Back-to-back: in_valid and out_ready held high, one result per D+2 cycles.
    for (int i = 0; i < 4; i++) rows[i] = rand_row();
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    a_i = rows[0];
    k = 0;
    got = 0;
    last_out = -1;
    for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
      acc = s_in_ready;
      if (acc) exp_q.push_back(a_i);
      if (s_out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_outputs("b2b", e);
        end else begin
          check_eq("b2b_unexpected_out", 1, 0);
        end
        if (last_out >= 0) check_eq("b2b_period", cyc - last_out, D + 2);
        last_out = cyc;
        got++;
      end
      step();
      if (acc) begin
        k++;
        a_i = (k < 4) ? rows[k] : rand_row();
      end
    end
    check_eq("b2b_count", got, 4);
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    step();

    // Reset after two elements have been combined aborts the row.
    run_row("pre_rst", rand_row(), 0);
    a_i = rand_row();
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    #1;
    check_eq("rst_async_in_ready", int'(s_in_ready && m_in_ready), 1);
    check_eq("rst_async_out_valid", int'(s_out_valid || m_out_valid), 0);
    check_eq("rst_async_result", int'(s_result), 0);
    step();
    rst_i = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_out_valid || m_out_valid) nvalid++;
    end
    check_eq("rst_no_stale_out", nvalid, 0);
    for (int i = 0; i < D; i++) r[i] = fixed_point_t'(ONE);
    run_row("ones", r, 0);
    check_eq("ones_sum_4", int'(s_result), 4 * ONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rowwise_reduce.md
ROWWISE_REDUCE -- requirements
Module: rowwise_reduce

Interface
REQ-001 Parameter: operation, type reduce_op_t, default SUM; selects reduction (SUM or MAX).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 a_i  input  vector_t (D x fixed_point_t)  row to reduce, typically vector_o of the upstream rowwise_operation stage.
REQ-005 in_valid_i  input  1  a_i valid.
REQ-006 in_ready_o  output  1  block can accept a row.
REQ-007 result_o  output  fixed_point_t  reduction result.
REQ-008 index_o  output  $clog2(D)  MAX: index of the maximum element; SUM: always 0.
REQ-009 out_valid_o  output  1  result_o/index_o valid.
REQ-010 out_ready_i  input  1  downstream accepts result.

Function
REQ-011 FSM states SHALL be WAITING_FOR_IN, WORKING, WAITING_FOR_OUT; in_ready_o = (state == WAITING_FOR_IN), out_valid_o = (state == WAITING_FOR_OUT), both purely from registered state.
REQ-012 Input handshake (in_valid_i & in_ready_o at an edge) SHALL latch all of a_i into an internal row register, clear the element counter, initialise the accumulator, and enter WORKING; a_i is don't-care afterwards.
REQ-013 Accumulator init: SUM -> 0; MAX -> most negative fixed_point_t value, stored index 0.
REQ-014 In WORKING, exactly one element (row[counter]) SHALL be combined per cycle, counter incrementing 0..D-1.
REQ-015 SUM: accumulator width = fixed_point_t width + $clog2(D) bits, signed, no intermediate overflow; final result saturated to fixed_point_t max/min.
REQ-016 MAX: signed compare; element replaces the running max only if strictly greater, so ties keep the lowest index.
REQ-017 On the edge processing element D-1, the FSM SHALL enter WAITING_FOR_OUT with result_o/index_o registered; out_valid_o rises exactly D edges after the accepting edge.
REQ-018 result_o and index_o SHALL remain stable while out_valid_o is high and out_ready_i is low.
REQ-019 Output handshake (out_valid_o & out_ready_i) SHALL return to WAITING_FOR_IN; in_ready_o rises the following cycle (no same-cycle output-release/input-accept; throughput one row per D+2 cycles).
REQ-020 in_valid_i while not in WAITING_FOR_IN SHALL be ignored; out_ready_i while not in WAITING_FOR_OUT SHALL be ignored.
REQ-021 result_o and index_o SHALL keep the last produced value after the output handshake until the next result is registered.

Reset
REQ-022 rst_i assertion SHALL immediately (asynchronously) force state WAITING_FOR_IN, counter 0, accumulator 0, row register 0, result_o 0, index_o 0; in_ready_o = 1, out_valid_o = 0 from reset release.
REQ-023 Reset during WORKING or WAITING_FOR_OUT SHALL discard the in-flight row; no out_valid_o for it after release.

Structure
REQ-024 reduce_op_t (SUM, MAX), saturating conversion function fixed_point_saturate, and D/fixed_point_t/vector_t SHALL live in config_pkg.
REQ-025 No sub-module; single FSM with combinational next-state block plus one registered block.

Verification (build with D=4)
REQ-026 SUM row {1.0, 2.0, -0.5, 0.25}, out_ready_i=1 -> out_valid_o high 4 edges after accept, result_o = 2.75, index_o = 0.
REQ-027 MAX row {-3.0, 5.0, 5.0, 1.0} -> result_o = 5.0, index_o = 1 (tie keeps lowest index).
REQ-028 SUM row of four fixed_point_t max values -> result_o = fixed_point_t max (saturated); four min values -> fixed_point_t min.
REQ-029 out_ready_i held low 10 cycles after out_valid_o -> result_o stable, in_ready_o low, new in_valid_i ignored; on release in_ready_o high next cycle.
REQ-030 Assert rst_i mid-WORKING (after 2 elements) -> in_ready_o=1, out_valid_o=0 immediately; next row {1,1,1,1} SUM -> 4.0 with no trace of aborted row.
REQ-031 Back-to-back rows with in_valid_i held high and out_ready_i=1 -> one result per D+2 cycles, each matching its own row; a_i changed after accept has no effect.
